// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: iterative multiply/divide unit with private HI/LO registers.
// Decodes mult/multu/div/divu/mthi/mtlo from OpCode/Funct. Multiplication is
// shift-add (LSB first), division is restoring (MSB first). Both take WIDTH
// iterations plus one sign-fix cycle.
// Optional feature macro: MDU_DIV_EN. When it is defined, div/divu and the
// restoring datapath are built. When it is undefined, div/divu decode as
// unrecognised ops.
module alu_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             illegal
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
`ifdef MDU_DIV_EN
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIX = 2'd2, DIV = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIX = 2'd2} state_t;
`endif

    // Conditional two's-complement negation. Used both for magnitude capture
    // and for the final sign fix; the most negative value maps to itself.
    function automatic logic signed [WIDTH-1:0] neg_w(input logic signed [WIDTH-1:0] x,
                                                      input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic signed [2*WIDTH-1:0] neg_2w(input logic signed [2*WIDTH-1:0] x,
                                                         input logic en);
        return en ? -x : x;
    endfunction

    state_t             state, state_nxt;
    logic               is_r, op_mult, op_div, op_mthi, op_mtlo, op_signed;
    logic               recognised, accept, iterating;
    logic [CW-1:0]      cnt;
    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
`ifdef MDU_DIV_EN
    logic               fix_div, bzero;
    logic [WIDTH-1:0]   dvsr, quo, rem;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic               trial_ok;
`endif

    // Decode the presented instruction and form the accept strobe.
    always_comb begin
        is_r      = (OpCode == 6'h00);
        op_mult   = is_r && ((Funct == F_MULT) || (Funct == F_MULTU));
`ifdef MDU_DIV_EN
        op_div    = is_r && ((Funct == F_DIV) || (Funct == F_DIVU));
`else
        op_div    = 1'b0;
`endif
        op_mthi   = is_r && (Funct == F_MTHI);
        op_mtlo   = is_r && (Funct == F_MTLO);
        // mult and div have even Funct codes, their unsigned forms odd ones.
        op_signed = ~Funct[0];
        recognised = op_mult || op_div || op_mthi || op_mtlo;
        accept    = in_valid && (state == IDLE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        iterating = (state == MUL);
        case (state)
            IDLE: begin
                if (accept && op_mult) state_nxt = MUL;
`ifdef MDU_DIV_EN
                if (accept && op_div)  state_nxt = DIV;
`endif
            end
            MUL: begin
                if (cnt == LAST) state_nxt = FIX;
            end
`ifdef MDU_DIV_EN
            DIV: begin
                iterating = 1'b1;
                if (cnt == LAST) state_nxt = FIX;
            end
`endif
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration counter and the registered done/illegal pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= (state == FIX);
            illegal <= accept && !recognised;
            if (accept) begin
                cnt <= '0;
            end else if (iterating) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Shift-add multiplier: the adder is one bit wider so the carry shifts
    // into the accumulator instead of being dropped.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};

    // Multiplier operand capture and iteration.
    always_ff @(posedge clk) begin
        if (accept && (op_mult || op_div)) begin
            sgn_a <= op_signed & a[WIDTH-1];
            sgn_b <= op_signed & b[WIDTH-1];
        end
        if (accept && op_mult) begin
            mcand <= neg_w(a, op_signed & a[WIDTH-1]);
            acc   <= {{WIDTH{1'b0}}, neg_w(b, op_signed & b[WIDTH-1])};
        end else if (state == MUL) begin
            if (acc[0]) begin
                acc <= {mul_sum, acc[WIDTH-1:1]};
            end else begin
                acc <= {1'b0, acc[2*WIDTH-1:1]};
            end
        end
    end

`ifdef MDU_DIV_EN
    // Restoring divider: the partial remainder is WIDTH+1 bits while the next
    // dividend bit is shifted in; a non-negative trial always fits WIDTH bits,
    // so both top bits of the trial must be clear for a quotient bit of 1.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_trial = {1'b0, div_shift} - {2'b00, dvsr};
    assign trial_ok  = (div_trial[WIDTH+1:WIDTH] == 2'b00);

    // Divider operand capture and iteration.
    always_ff @(posedge clk) begin
        if (accept && (op_mult || op_div)) begin
            fix_div <= op_div;
        end
        if (accept && op_div) begin
            dvsr  <= neg_w(b, op_signed & b[WIDTH-1]);
            quo   <= neg_w(a, op_signed & a[WIDTH-1]);
            rem   <= '0;
            bzero <= (b == '0);
        end else if (state == DIV) begin
            rem <= trial_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], trial_ok};
        end
    end
`endif

    // Sign fix-up of the finished result. A zero divisor leaves the dividend
    // in the remainder and all ones in the quotient, so only LO needs forcing.
    always_comb begin
        prod   = neg_2w(acc, sgn_a ^ sgn_b);
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (fix_div) begin
            fix_hi = neg_w(rem, sgn_a);
            fix_lo = bzero ? {WIDTH{1'b1}} : neg_w(quo, sgn_a ^ sgn_b);
        end
`endif
    end

    // HI/LO registers: written by mthi/mtlo on accept or by the FIX cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (accept && op_mthi) hi <= a;
            if (accept && op_mtlo) lo <= a;
            if (state == FIX) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Testbench for alu_muldiv_unit (WIDTH=32). Results of mult/div operations are
// queued when issued and compared by a monitor when done pulses. Division
// tests follow MDU_DIV_EN; without it div/divu are expected to be illegal.
module tb_alu_muldiv_unit;
    localparam int W = 32;

    logic         clk, reset, in_valid, in_ready;
    logic [5:0]   OpCode, Funct;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done, illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } exp_t;

    exp_t exp_q[$];

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .OpCode(OpCode), .Funct(Funct), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model for back-to-back traffic (64-bit host arithmetic).
    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        r;
        logic [63:0] p;
        logic [63:0] qv, rv;
        longint      sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        case (f)
            6'h18: p = sx * sy;
            6'h19: p = {32'h0, x} * {32'h0, y};
            6'h1a: begin
                if (y == 0) p = {x, 32'hFFFFFFFF};
                else begin
                    qv = sx / sy;
                    rv = sx % sy;
                    p  = {rv[31:0], qv[31:0]};
                end
            end
            6'h1b: begin
                if (y == 0) p = {x, 32'hFFFFFFFF};
                else p = {x % y, x / y};
            end
            default: p = '0;
        endcase
        r.hi   = p[63:32];
        r.lo   = p[31:0];
        r.name = "b2b";
        return r;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest queued result.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: hi=%h lo=%h with no result pending", hi, lo);
            end else begin
                e = exp_q.pop_front();
                if (hi !== e.hi || lo !== e.lo) begin
                    errors++;
                    $display("FAIL %s: got hi=%h lo=%h want hi=%h lo=%h", e.name, hi, lo, e.hi, e.lo);
                end
            end
        end
    end

    // Present one op, wait for acceptance, then drop in_valid.
    task automatic do_op(input logic [5:0] op, input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            n++;
            step();
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready=%b want 1", in_ready);
        end
        OpCode = op; Funct = f; a = x; b = y; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            n++;
            step();
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; OpCode = '0; Funct = '0; a = '0; b = '0;
        step(); step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (illegal !== 1'b0)  begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        checks++; if (hi !== 32'h0)      begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0)      begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        reset = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: in_ready=%b busy=%b want 1/0", in_ready, busy); end
    endtask

    task automatic test_multu_latency();
        int nb = 0;
        exp_q.push_back('{32'hFFFFFFFE, 32'h00000001, "multu_max"});
        do_op(6'h00, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        while (busy === 1'b1 && nb < 100) begin
            nb++;
            step();
        end
        checks++; if (nb != 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", nb); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL multu_done_cycle: done=%b want 1", done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL multu_ready_on_done: got %b want 1", in_ready); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse_len: done=%b want 0", done); end
    endtask

    task automatic test_mult();
        exp_q.push_back('{32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3_5"});
        do_op(6'h00, 6'h18, 32'hFFFFFFFD, 32'h00000005);
        wait_idle();
        exp_q.push_back('{32'h40000000, 32'h00000000, "mult_minneg_sq"});
        do_op(6'h00, 6'h18, 32'h80000000, 32'h80000000);
        wait_idle();
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        exp_q.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2"});
        do_op(6'h00, 6'h1a, 32'hFFFFFFF9, 32'h00000002);
        wait_idle();
        exp_q.push_back('{32'h00000000, 32'h80000000, "div_overflow"});
        do_op(6'h00, 6'h1a, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        exp_q.push_back('{32'h00000007, 32'hFFFFFFFF, "divu_by_zero"});
        do_op(6'h00, 6'h1b, 32'h00000007, 32'h00000000);
        wait_idle();
        exp_q.push_back('{32'hFFFFFFF8, 32'hFFFFFFFF, "div_neg_by_zero"});
        do_op(6'h00, 6'h1a, 32'hFFFFFFF8, 32'h00000000);
        wait_idle();
    endtask
`else
    task automatic test_div_disabled();
        logic [5:0] fl[2];
        fl[0] = 6'h1a;
        fl[1] = 6'h1b;
        do_op(6'h00, 6'h11, 32'h11112222, 32'h0);
        do_op(6'h00, 6'h13, 32'h33334444, 32'h0);
        for (int k = 0; k < 2; k++) begin
            do_op(6'h00, fl[k], 32'd100, 32'd7);
            checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL nodiv_illegal: got %b want 1", illegal); end
            checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL nodiv_busy: busy=%b in_ready=%b want 0/1", busy, in_ready); end
            checks++; if (hi !== 32'h11112222 || lo !== 32'h33334444) begin errors++; $display("FAIL nodiv_hilo: hi=%h lo=%h want 11112222/33334444", hi, lo); end
            step();
            checks++; if (illegal !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL nodiv_after: illegal=%b busy=%b want 0/0", illegal, busy); end
        end
    endtask
`endif

    task automatic test_busy_hold();
        int n = 0;
        int seen = 0;
        exp_q.push_back('{32'h00000000, 32'h0000002A, "mult_6x7"});
        do_op(6'h00, 6'h18, 32'd6, 32'd7);
        OpCode = 6'h00; Funct = 6'h11; a = 32'h00001234; b = 32'h0; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            if (hi === 32'h00001234) seen++;
            n++;
            step();
        end
        checks++; if (n != 33) begin errors++; $display("FAIL hold_not_ready_cycles: got %0d want 33", n); end
        checks++; if (seen != 0) begin errors++; $display("FAIL hold_mthi_early: early cycles %0d want 0", seen); end
        step();
        in_valid = 1'b0;
        checks++; if (hi !== 32'h00001234 || lo !== 32'h0000002A) begin errors++; $display("FAIL hold_mthi_after: hi=%h lo=%h want 00001234/0000002a", hi, lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_mthi_busy: got %b want 0", busy); end
    endtask

    task automatic test_illegal();
        do_op(6'h00, 6'h11, 32'hAAAA5555, 32'h0);
        checks++; if (hi !== 32'hAAAA5555) begin errors++; $display("FAIL mthi_value: got %h want aaaa5555", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL mthi_flags: busy=%b done=%b illegal=%b want 000", busy, done, illegal); end
        do_op(6'h00, 6'h13, 32'h0F0F0F0F, 32'h0);
        checks++; if (lo !== 32'h0F0F0F0F || hi !== 32'hAAAA5555) begin errors++; $display("FAIL mtlo_value: hi=%h lo=%h want aaaa5555/0f0f0f0f", hi, lo); end
        do_op(6'h00, 6'h2a, 32'h1, 32'h2);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_funct: got %b want 1", illegal); end
        checks++; if (hi !== 32'hAAAA5555 || lo !== 32'h0F0F0F0F) begin errors++; $display("FAIL illegal_hilo: hi=%h lo=%h want aaaa5555/0f0f0f0f", hi, lo); end
        step();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse_len: got %b want 0", illegal); end
        do_op(6'h01, 6'h18, 32'h3, 32'h4);
        checks++; if (illegal !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL illegal_opcode: illegal=%b busy=%b want 1/0", illegal, busy); end
        step();
        checks++; if (hi !== 32'hAAAA5555 || lo !== 32'h0F0F0F0F || busy !== 1'b0) begin errors++; $display("FAIL illegal_opcode_hilo: hi=%h lo=%h busy=%b", hi, lo, busy); end
    endtask

    task automatic test_reset_mid_op();
        int nd = 0;
`ifdef MDU_DIV_EN
        do_op(6'h00, 6'h1a, 32'd100, 32'd7);
`else
        do_op(6'h00, 6'h19, 32'd100, 32'd7);
`endif
        repeat (9) step();
        reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midreset_hilo: hi=%h lo=%h want 0/0", hi, lo); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midreset_ready: in_ready=%b busy=%b want 1/0", in_ready, busy); end
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) nd++;
            step();
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL midreset_done: pulses %0d want 0", nd); end
        exp_q.push_back('{32'h00000000, 32'h0000000C, "multu_3x4"});
        do_op(6'h00, 6'h19, 32'd3, 32'd4);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [5:0]   ops[$];
        logic [5:0]   f;
        logic [W-1:0] x, y;
        int           n;
        ops = {6'h18, 6'h19};
`ifdef MDU_DIV_EN
        ops.push_back(6'h1a);
        ops.push_back(6'h1b);
`endif
        wait_idle();
        for (int k = 0; k < 8; k++) begin
            f = ops[k % ops.size()];
            x = $urandom();
            y = $urandom();
            if (k == 0) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            if (k == 5) y = 32'h0;
            if (k == 6) y = $urandom_range(1, 15);
            exp_q.push_back(model(f, x, y));
            do_op(6'h00, f, x, y);
            n = 0;
            while (in_ready !== 1'b1 && n < 100) begin
                n++;
                step();
            end
            checks++; if (n != 33) begin errors++; $display("FAIL b2b_interval op%0d: got %0d want 33", k, n); end
        end
    endtask

    initial begin
        int n = 0;
        test_reset();
        test_multu_latency();
        test_mult();
`ifdef MDU_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_busy_hold();
        test_illegal();
        test_reset_mid_op();
        test_back_to_back();
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            step();
        end
        step();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL results_outstanding: got %0d want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_unit.md
# alu_muldiv_unit

Parametrised iterative multiply/divide unit with private HI/LO registers, the multi-cycle companion to the single-cycle ALU control/ALU pair in the execute stage. It decodes the R-type Funct field for mult/multu/div/divu/mthi/mtlo itself, runs shift-add multiplication or restoring division over WIDTH cycles, and exposes HI/LO plus a busy flag. The pipeline hazard unit uses the busy flag to stall mfhi/mflo and any further HI/LO operation.

## Interface
- WIDTH, 32, operand/HI/LO width in bits; legal range 4..64.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  unit can accept; equals (state==IDLE).
- OpCode  in  6  must be 6'h00 for any recognised op.
- Funct  in  6  6'h18 mult, 6'h19 multu, 6'h1a div, 6'h1b divu, 6'h11 mthi, 6'h13 mtlo.
- a  in  WIDTH  rs operand (multiplicand/dividend; mthi/mtlo source).
- b  in  WIDTH  rt operand (multiplier/divisor).
- hi  out  WIDTH  HI register (remainder / product upper half).
- lo  out  WIDTH  LO register (quotient / product lower half).
- busy  out  1  iterative operation in flight.
- done  out  1  one-cycle pulse after HI/LO written by mult/div.
- illegal  out  1  one-cycle pulse: accepted op not recognised.

## Operation
- Accept = in_valid & in_ready at a rising edge. Nothing is accepted outside IDLE; in_valid outside IDLE is ignored, not queued.
- States: IDLE, MUL, DIV, FIX.
  - IDLE → MUL on accepted mult/multu.
  - IDLE → DIV on accepted div/divu.
  - MUL/DIV → FIX after WIDTH iterations.
  - FIX → IDLE unconditionally.
- Operand capture on accept:
  - Signed ops latch |a|, |b| plus sign flags.
  - Unsigned ops latch raw values with sign flags 0.
  - Magnitudes are WIDTH-bit unsigned, so the most negative value maps to itself.
- MUL, one iteration per cycle, LSB first:
  - Conditional add into a 2·WIDTH accumulator, then shift.
  - The add carry must not be lost (WIDTH+1-bit adder).
- DIV, one restoring step per cycle, MSB first:
  - Remainder is WIDTH+1 bits.
  - Quotient bit = 1 when the trial subtract is non-negative.
- FIX writes HI/LO.
  - Mult: product negated (2·WIDTH two's complement) iff sign_a^sign_b; HI = upper half, LO = lower half.
  - Div: quotient negated iff sign_a^sign_b; remainder negated iff sign_a (remainder takes the dividend's sign).
- Division by zero (b==0): HI = a, LO = all ones, for both div and divu. Still takes full latency.
- Signed overflow, most-negative ÷ −1: LO = most-negative, HI = 0. This falls out of the magnitude scheme; no special case.
- mthi/mtlo: HI or LO ← a at the accept edge. State stays IDLE; busy, done and illegal stay 0.
- Unrecognised Funct, or OpCode≠0, while accepted: HI/LO unchanged, illegal=1 for the following cycle.
- reset at any time: state=IDLE, HI=LO=0, counter=0, done=illegal=0. An in-flight operation is discarded and produces no done pulse.

## Timing
- Reset values: in_ready=1, busy=0, done=0, illegal=0, hi=0, lo=0.
- Mult/div: accept at edge E0; iterations at E1..E_WIDTH; FIX writes HI/LO at E_WIDTH+1.
  - busy=1 from after E0 until E_WIDTH+1 (WIDTH+1 cycles).
  - done=1 for the single cycle after E_WIDTH+1, while in_ready is already 1.
  - A new op may be accepted at the edge ending the done cycle (back-to-back throughput WIDTH+2 cycles).
- mthi/mtlo: hi/lo show the new value the cycle after the accept edge. Back-to-back every cycle is allowed.
- hi/lo are registered outputs and never change except at a FIX edge, an mthi/mtlo accept, or reset.
- illegal and done are registered single-cycle pulses.

## Configuration
- MDU_DIV_EN defined: div/divu behave as above; DIV state and restoring datapath are built.
- MDU_DIV_EN undefined:
  - DIV state and its datapath are not synthesised.
  - Funct 6'h1a/6'h1b are treated as unrecognised: accepted in IDLE, HI/LO unchanged, illegal pulses, busy stays 0.

## Test plan
All cases WIDTH=32, MDU_DIV_EN defined unless stated.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. busy high 33 cycles; done pulses in cycle 34 after accept.
- mult a=−3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then mult a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
- div a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. divu a=7, b=0 → hi=7, lo=0xFFFFFFFF.
- Busy behaviour: start mult, hold in_valid with mthi a=0x1234 → in_ready=0 throughout, mthi taken only after done; final hi=0x1234.
- Illegal ops: Funct=6'h2a accepted → illegal pulse, hi/lo unchanged. Rebuild without MDU_DIV_EN: div → illegal pulse, busy never asserts.
- Reset mid-op: assert reset at iteration 10 of a div → next cycle hi=lo=0, in_ready=1, no done pulse; a following multu 3×4 gives lo=12.
